// File: rtl/rs_wake_array.sv
// Reservation-station wakeup/select array: multi-port allocation, tag-broadcast wakeup
// with speculative cancel, per-port lowest-index select, and per-thread flush.
module rs_wake_array #(
    parameter int DEPTH = 8,
    parameter int NWR   = 3,
    parameter int NISS  = 3,
    parameter int NSRC  = 3,
    parameter int NFU   = 4,
    parameter int TAGW  = 6,
    localparam int IW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR*NISS-1:0]      wr_port,
    input  logic [NWR-1:0]           wr_thr,
    input  logic [NWR*NSRC*TAGW-1:0] wr_tag,
    input  logic [NWR*NSRC-1:0]      wr_rdy,
    output logic                     in_rdy,
    input  logic [NFU-1:0]           wk_vld,
    input  logic [NFU-1:0]           wk_spec,
    input  logic [NFU*TAGW-1:0]      wk_tag,
    input  logic                     spec_miss,
    output logic [NISS-1:0]          iss_req,
    output logic [NISS*IW-1:0]       iss_idx,
    input  logic [NISS-1:0]          iss_take,
    output logic [NISS-1:0]          iss_vld,
    output logic [NISS*IW-1:0]       iss_vidx,
    input  logic                     flush,
    input  logic                     flush_thr,
    output logic [CW-1:0]            free_cnt,
    output logic                     buf_empty
);
    localparam int KW = (NWR > 1) ? $clog2(NWR) : 1;

    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   entThr;
    logic [NISS-1:0]    entPort  [DEPTH];
    logic [TAGW-1:0]    entTag   [DEPTH][NSRC];
    logic [NSRC-1:0]    entRdy   [DEPTH];
    logic [NSRC-1:0]    entSpec  [DEPTH];

    logic               allocOk;
    logic [NWR-1:0]     wrLive;
    logic [DEPTH-1:0]   allocV;
    logic [KW-1:0]      allocK   [DEPTH];
    logic [NSRC-1:0]    rdyNext  [DEPTH];
    logic [NSRC-1:0]    specNext [DEPTH];
    logic [IW-1:0]      selIdx   [NISS];
    logic [NISS-1:0]    issueFire;
    logic [NISS*IW-1:0] vidxNext;
    logic [DEPTH-1:0]   validNext;
    logic [CW-1:0]      freeNext;

    assign in_rdy    = free_cnt >= CW'(NWR);
    assign buf_empty = free_cnt == CW'(DEPTH);
    assign allocOk   = in_rdy && !stall;

    // Live port k lands on the free entry whose free-rank equals k's rank among live ports.
    always_comb begin
        logic [CW-1:0] ordinal [NWR];
        logic [CW-1:0] seen;
        logic [CW-1:0] rank;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        wrLive = '0;
        allocV = '0;
        seen   = '0;
        rank   = '0;
        for (int k = 0; k < NWR; k++) begin
            wrLive[k]  = allocOk && wr_en[k] && !(flush && wr_thr[k] == flush_thr);
            ordinal[k] = seen;
            seen       = seen + CW'(wrLive[k]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            allocK[i] = '0;
            if (!valid[i]) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wrLive[k] && ordinal[k] == rank) begin
                        allocV[i] = 1'b1;
                        allocK[i] = KW'(k);
                    end
                end
                rank = rank + CW'(1);
            end
        end
    end

    // Wakeup only touches sources not already ready, so a settled source never turns speculative.
    always_comb begin
        logic            base;
        logic [TAGW-1:0] srcTag;
        logic            anyHit;
        logic            safeHit;
        base    = 1'b0;
        srcTag  = '0;
        anyHit  = 1'b0;
        safeHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (allocV[i]) begin
                    base   = wr_rdy[int'(allocK[i]) * NSRC + s];
                    srcTag = wr_tag[(int'(allocK[i]) * NSRC + s) * TAGW +: TAGW];
                end else begin
                    base   = entRdy[i][s] && !(entSpec[i][s] && spec_miss);
                    srcTag = entTag[i][s];
                end
                anyHit  = 1'b0;
                safeHit = 1'b0;
                for (int f = 0; f < NFU; f++) begin
                    if (wk_vld[f] && wk_tag[f*TAGW +: TAGW] == srcTag) begin
                        anyHit = 1'b1;
                        if (!wk_spec[f]) safeHit = 1'b1;
                    end
                end
                rdyNext[i][s]  = base || anyHit;
                specNext[i][s] = !base && anyHit && !safeHit;
            end
        end
    end

    always_comb begin
        iss_req   = '0;
        iss_idx   = '0;
        issueFire = '0;
        vidxNext  = '0;
        // NOTE: blocking assignments here are deliberate: later clears refine earlier values.
        validNext = valid | allocV;
        for (int p = 0; p < NISS; p++) begin
            selIdx[p] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (valid[i] && (&entRdy[i]) && entPort[i][p]) begin
                    iss_req[p] = 1'b1;
                    selIdx[p]  = IW'(i);
                end
            end
            iss_idx[p*IW +: IW] = selIdx[p];
            if (iss_take[p] && iss_req[p] && !stall && !(spec_miss && (|entSpec[selIdx[p]]))) begin
                validNext[selIdx[p]] = 1'b0;
                if (!(flush && entThr[selIdx[p]] == flush_thr)) begin
                    issueFire[p]          = 1'b1;
                    vidxNext[p*IW +: IW]  = selIdx[p];
                end
            end
        end
        freeNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush && valid[i] && entThr[i] == flush_thr) validNext[i] = 1'b0;
            freeNext = freeNext + CW'(!validNext[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            free_cnt <= CW'(DEPTH);
            iss_vld  <= '0;
            iss_vidx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entRdy[i]  <= '0;
                entSpec[i] <= '0;
            end
        end else begin
            valid    <= validNext;
            free_cnt <= freeNext;
            iss_vld  <= issueFire;
            iss_vidx <= vidxNext;
            for (int i = 0; i < DEPTH; i++) begin
                entRdy[i]  <= rdyNext[i];
                entSpec[i] <= specNext[i];
            end
        end
    end

    // NOTE: payload fields are not reset; they are only meaningful while valid is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (allocV[i]) begin
                entPort[i] <= wr_port[int'(allocK[i]) * NISS +: NISS];
                entThr[i]  <= wr_thr[allocK[i]];
                for (int s = 0; s < NSRC; s++)
                    entTag[i][s] <= wr_tag[(int'(allocK[i]) * NSRC + s) * TAGW +: TAGW];
            end
        end
    end

endmodule
